// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI requester arbiter: FSM states,
// engine status bit positions and command-word field positions.
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    RESPOND    = 3'd4
  } state_e;

  localparam int BUSY_BIT          = 31;
  localparam int RB_W              = 24;
  localparam int CMD_LARGE_BIT     = 31;
  localparam int CMD_LSB_FIRST_BIT = 30;
  localparam int CMD_DEV_SEL_BASE  = 24;

  function automatic logic [5:0] cmd_dev_sel(input logic [31:0] word);
    return word[CMD_DEV_SEL_BASE +: 6];
  endfunction

  function automatic logic [1:0] cmd_mode(input logic [31:0] word);
    return {word[CMD_LARGE_BIT], word[CMD_LSB_FIRST_BIT]};
  endfunction

endpackage

// File: rtl/spi_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin pick, searching upward from
// the index after last_i and wrapping at NREQ.
module rr_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic             found_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan candidates last+1 .. last+NREQ (mod NREQ), take the first requester.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum_s  = {1'b0, last_i} + (IDX_W+1)'(k);
      sum_s  = (sum_s >= (IDX_W+1)'(NREQ)) ? (sum_s - (IDX_W+1)'(NREQ)) : sum_s;
      cand_s = sum_s[IDX_W-1:0];
      if (!found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        gnt_idx_o     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates NREQ requesters onto one SPI engine, one transfer at a time.
// Optional engine-busy timeout: define SPI_ARBITER_TIMEOUT_EN.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_word,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RB_W-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 spi_strobe,
  output logic [31:0]          spi_word,
  input  logic [31:0]          spi_status
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [RB_W-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d, strobe_q, strobe_d, ws_cnt_q, ws_cnt_d;
  logic [31:0]       word_q, word_d, word_sel_s;
  logic [NREQ-1:0]   rr_gnt_s, gnt_oh_s;
  logic [IDX_W-1:0]  rr_idx_s;
  logic              busy_s;
  logic [6:0]        status_unused_s;

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  assign busy_s          = spi_status[BUSY_BIT];
  assign status_unused_s = spi_status[30:24];
  assign gnt_oh_s        = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_q;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (req_valid),
    .last_i    (last_q),
    .gnt_o     (rr_gnt_s),
    .gnt_idx_o (rr_idx_s)
  );

  // Command word of the requester the round-robin picked.
  always_comb begin
    word_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_gnt_s[i]) begin
        word_sel_s = req_word[32*i +: 32];
      end else begin
        word_sel_s = word_sel_s;
      end
    end
  end

  // Next-state and registered-output decode; outputs are set on entry to a state.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_idx_d   = gnt_idx_q;
    word_d      = word_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ws_cnt_d    = ws_cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    strobe_d    = 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !busy_s) begin
          state_d     = ISSUE;
          req_ready_d = rr_gnt_s;
          word_d      = word_sel_s;
          gnt_idx_d   = rr_idx_s;
          last_d      = rr_idx_s;
          strobe_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d  = WAIT_START;
        ws_cnt_d = 1'b0;
      end
      WAIT_START: begin
        if (busy_s) begin
          state_d = WAIT_DONE;
`ifdef SPI_ARBITER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (ws_cnt_q) begin
          // Engine never went busy: report the missed strobe as an error.
          state_d     = RESPOND;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_oh_s;
        end else begin
          ws_cnt_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_s) begin
          state_d     = RESPOND;
          rsp_data_d  = spi_status[RB_W-1:0];
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_oh_s;
        end else begin
`ifdef SPI_ARBITER_TIMEOUT_EN
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = RESPOND;
            rsp_err_d   = 1'b1;
            rsp_valid_d = gnt_oh_s;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`else
          state_d = WAIT_DONE;
`endif
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; pointer resets to NREQ-1 so the first grant scans from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      gnt_idx_q   <= '0;
      word_q      <= 32'h0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ws_cnt_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      strobe_q    <= 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_idx_q   <= gnt_idx_d;
      word_q      <= word_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ws_cnt_q    <= ws_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      strobe_q    <= strobe_d;
`ifdef SPI_ARBITER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign spi_strobe = strobe_q;
  assign spi_word   = word_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI engine model.
module tb_spi_arbiter;

  localparam int NREQ = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_word;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [23:0]        rsp_data;
  logic               rsp_err;
  logic               spi_strobe;
  logic [31:0]        spi_word;
  logic [31:0]        spi_status;

  spi_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_word   (req_word),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .spi_strobe (spi_strobe),
    .spi_word   (spi_word),
    .spi_status (spi_status)
  );

  always #5 clk = ~clk;

  // Engine model: busy for eng_len cycles after a strobe, or never (ignore), or stuck (hold).
  logic        eng_busy = 1'b0;
  int          eng_cnt  = 0;
  int          eng_len  = 10;
  logic        eng_ignore = 1'b0;
  logic        eng_hold   = 1'b0;
  logic [23:0] eng_rb     = 24'h0;

  assign spi_status = {eng_busy, 7'b0, eng_rb};

  always @(posedge clk) begin
    if (spi_strobe && !eng_ignore) begin
      eng_busy <= 1'b1;
      eng_cnt  <= eng_len - 1;
    end else if (eng_busy && !eng_hold) begin
      if (eng_cnt == 0) eng_busy <= 1'b0;
      else              eng_cnt  <= eng_cnt - 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grants[$], ready_cyc[$], rsp_idx[$], rsp_cyc[$], events[$];
  logic [23:0] rsp_dat[$];
  logic        rsp_e[$];
  int          strobes = 0;
  logic [31:0] strobe_word = 32'h0;
  int          multi_ready = 0;
  int          ready_while_busy = 0;
  logic        prev_busy = 1'b0;
  logic [NREQ-1:0] keep = '0;
  int          stop_grants = 1000;

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if ($countones(req_ready) > 1) multi_ready++;
    if (spi_strobe) begin
      strobes++;
      strobe_word = spi_word;
    end
    if (req_ready != '0) begin
      if (prev_busy) ready_while_busy++;
      grants.push_back(oh2idx(req_ready));
      ready_cyc.push_back(cyc);
      events.push_back(oh2idx(req_ready));
      req_valid = req_valid & ~(req_ready & ~keep);
      if (grants.size() >= stop_grants) begin
        keep      = '0;
        req_valid = '0;
      end
    end
    if (rsp_valid != '0) begin
      rsp_idx.push_back(oh2idx(rsp_valid));
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_data);
      rsp_e.push_back(rsp_err);
      events.push_back(10 + oh2idx(rsp_valid));
    end
    prev_busy = spi_status[31];
  endtask

  task automatic clr();
    grants.delete(); ready_cyc.delete(); rsp_idx.delete(); rsp_cyc.delete();
    events.delete(); rsp_dat.delete(); rsp_e.delete();
    strobes = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rsp(input int n, input int bound, input string tag);
    int b = 0;
    while (rsp_idx.size() < n && b < bound) begin
      step();
      b++;
    end
    chk(tag, rsp_idx.size(), n);
  endtask

  task automatic wait_grants(input int n, input int bound, input string tag);
    int b = 0;
    while (grants.size() < n && b < bound) begin
      step();
      b++;
    end
    chk(tag, grants.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int exp_ev[8] = '{0, 10, 1, 11, 2, 12, 3, 13};
    rst_n     = 1'b0;
    req_valid = '0;
    req_word  = '0;

    // Reset state
    wait_cycles(2);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_rsp_data", rsp_data, 24'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_strobe", spi_strobe, 1'b0);
    chk("rst_spi_word", spi_word, 32'h0);
    rst_n = 1'b1;
    step();

    // Single request from requester 2, engine busy 200 cycles
    clr();
    eng_len = 200;
    eng_rb  = 24'hABCDEF;
    req_word[64 +: 32] = 32'h8012_3456;
    req_valid = 4'b0100;
    wait_rsp(1, 400, "single_rsp_seen");
    chk("single_grant_cnt", grants.size(), 1);
    chk("single_grant_idx", grants[0], 2);
    chk("single_strobes", strobes, 1);
    chk("single_strobe_word", strobe_word, 32'h8012_3456);
    chk("single_word_stable", spi_word, 32'h8012_3456);
    chk("single_rsp_idx", rsp_idx[0], 2);
    chk("single_rsp_data", rsp_dat[0], 24'hABCDEF);
    chk("single_rsp_err", rsp_e[0], 1'b0);
    chk("single_latency", rsp_cyc[0] - ready_cyc[0], 202);
    wait_cycles(5);
    chk("single_rsp_once", rsp_idx.size(), 1);
    chk("single_data_hold", rsp_data, 24'hABCDEF);

    // All four requesters at once after reset
    do_reset();
    clr();
    eng_len = 5;
    eng_rb  = 24'h111111;
    for (int i = 0; i < NREQ; i++) req_word[32*i +: 32] = 32'hA000_0000 | 32'(i);
    req_valid = 4'hF;
    wait_rsp(4, 300, "all4_rsp_seen");
    chk("all4_event_cnt", events.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("all4_event%0d", i), events[i], exp_ev[i]);

    // Requesters 1 and 3 hold their requests
    clr();
    eng_rb      = 24'h5A5A5A;
    keep        = 4'b1010;
    stop_grants = 4;
    req_valid   = 4'b1010;
    wait_rsp(4, 400, "alt_rsp_seen");
    stop_grants = 1000;
    chk("alt_grant0", grants[0], 1);
    chk("alt_grant1", grants[1], 3);
    chk("alt_grant2", grants[2], 1);
    chk("alt_grant3", grants[3], 3);
    chk("alt_rsp_data", rsp_dat[3], 24'h5A5A5A);

    // Engine ignores the strobe
    clr();
    eng_rb     = 24'h0F0F0F;
    eng_ignore = 1'b1;
    req_valid  = 4'b0001;
    wait_rsp(1, 50, "miss_rsp_seen");
    chk("miss_grant", grants[0], 0);
    chk("miss_rsp_err", rsp_e[0], 1'b1);
    chk("miss_latency", rsp_cyc[0] - ready_cyc[0], 3);
    chk("miss_data_hold", rsp_data, 24'h5A5A5A);
    eng_ignore = 1'b0;
    clr();
    req_valid = 4'b0100;
    wait_rsp(1, 100, "after_miss_rsp_seen");
    chk("after_miss_grant", grants[0], 2);
    chk("after_miss_err", rsp_e[0], 1'b0);
    chk("after_miss_data", rsp_dat[0], 24'h0F0F0F);

    // Engine stuck busy
    clr();
    eng_len   = 10;
    eng_hold  = 1'b1;
    req_valid = 4'b0010;
`ifdef SPI_ARBITER_TIMEOUT_EN
    wait_rsp(1, 200, "tmo_rsp_seen");
    chk("tmo_rsp_err", rsp_e[0], 1'b1);
    chk("tmo_latency", rsp_cyc[0] - ready_cyc[0], 66);
    req_valid = 4'b1000;
    wait_cycles(30);
    chk("tmo_blocked", grants.size(), 1);
    eng_hold = 1'b0;
    wait_rsp(2, 100, "tmo_next_rsp_seen");
    chk("tmo_next_grant", grants[1], 3);
    chk("tmo_next_err", rsp_e[1], 1'b0);
`else
    wait_cycles(300);
    chk("stuck_no_rsp", rsp_idx.size(), 0);
    eng_hold = 1'b0;
    wait_rsp(1, 100, "stuck_rsp_seen");
    chk("stuck_rsp_idx", rsp_idx[0], 1);
    chk("stuck_rsp_err", rsp_e[0], 1'b0);
`endif

    // Reset in the middle of WAIT_DONE
    clr();
    eng_len   = 100;
    req_valid = 4'b0100;
    wait_grants(1, 50, "midrst_grant_seen");
    wait_cycles(20);
    clr();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 4'h0);
    chk("midrst_rsp_valid", rsp_valid, 4'h0);
    chk("midrst_rsp_data", rsp_data, 24'h0);
    chk("midrst_rsp_err", rsp_err, 1'b0);
    chk("midrst_strobe", spi_strobe, 1'b0);
    chk("midrst_spi_word", spi_word, 32'h0);
    wait_cycles(3);
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    wait_rsp(2, 400, "midrst_rsp_seen");
    chk("midrst_first_event", events[0], 0);
    chk("midrst_grant0", grants[0], 0);
    chk("midrst_grant1", grants[1], 3);

    chk("ready_onehot", multi_ready, 0);
    chk("no_grant_while_busy", ready_while_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
